// File: rtl/video_bus_arb.sv
// Two-requester arbiter and sequencer for the video host port.
// Round-robin grant, registered strobes, fixed read latency.
module video_bus_arb #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 8,
  parameter int RD_LAT     = 1,
  parameter int BLANK_ONLY = 0
) (
  input  logic              clk,
  input  logic              NRST,
  input  logic              vid_blank,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic              r0_ctl,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic              r1_ctl,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              sel_ram,
  output logic              sel_ctl,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic [DATA_W-1:0] ctl_dout,
  output logic              busy
);

  localparam logic [2:0] LAT  = 3'(RD_LAT);
  localparam logic       GATE = (BLANK_ONLY != 0);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK
  } state_t;

  state_t              state, state_n;
  logic                lat_id, lat_id_n;
  logic                lat_we, lat_we_n;
  logic                lat_ctl, lat_ctl_n;
  logic                last_grant, last_n;
  logic [2:0]          cnt, cnt_n;
  logic                sel_ram_n, sel_ctl_n, we_n;
  logic                ack0_n, ack1_n, busy_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [DATA_W-1:0]   din_n, rdata_n;
  logic                el0, el1, gid, g_ctl;

  // Eligibility: control accesses are never gated by blanking.
  always_comb begin
    el0 = r0_req & (r0_ctl | ~GATE | vid_blank);
    el1 = r1_req & (r1_ctl | ~GATE | vid_blank);
  end

  // Next-state and next-output logic; all outputs are registered.
  always_comb begin
    state_n   = state;
    lat_id_n  = lat_id;
    lat_we_n  = lat_we;
    lat_ctl_n = lat_ctl;
    last_n    = last_grant;
    cnt_n     = cnt;
    sel_ram_n = 1'b0;
    sel_ctl_n = 1'b0;
    we_n      = 1'b0;
    ack0_n    = 1'b0;
    ack1_n    = 1'b0;
    addr_n    = addr;
    din_n     = din;
    rdata_n   = rdata;
    gid       = 1'b0;
    g_ctl     = 1'b0;
    unique case (state)
      IDLE: begin
        if (el0 | el1) begin
          gid       = (el0 & el1) ? ~last_grant : el1;
          g_ctl     = gid ? r1_ctl : r0_ctl;
          lat_id_n  = gid;
          lat_we_n  = gid ? r1_we : r0_we;
          lat_ctl_n = g_ctl;
          last_n    = gid;
          sel_ram_n = ~g_ctl;
          sel_ctl_n = g_ctl;
          we_n      = gid ? r1_we : r0_we;
          addr_n    = gid ? r1_addr : r0_addr;
          din_n     = gid ? r1_wdata : r0_wdata;
          state_n   = ISSUE;
        end
      end
      ISSUE: begin
        if (lat_we) begin
          ack0_n  = ~lat_id;
          ack1_n  = lat_id;
          state_n = ACK;
        end else begin
          cnt_n   = LAT;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 3'd1) begin
          rdata_n = lat_ctl ? ctl_dout : ram_dout;
          ack0_n  = ~lat_id;
          ack1_n  = lat_id;
          state_n = ACK;
        end else begin
          cnt_n = cnt - 3'd1;
        end
      end
      ACK: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // State, latched command and registered outputs.
  always_ff @(posedge clk or negedge NRST) begin
    if (!NRST) begin
      state      <= IDLE;
      lat_id     <= 1'b0;
      lat_we     <= 1'b0;
      lat_ctl    <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= 3'd0;
      sel_ram    <= 1'b0;
      sel_ctl    <= 1'b0;
      we         <= 1'b0;
      r0_ack     <= 1'b0;
      r1_ack     <= 1'b0;
      busy       <= 1'b0;
      addr       <= '0;
      din        <= '0;
      rdata      <= '0;
    end else begin
      state      <= state_n;
      lat_id     <= lat_id_n;
      lat_we     <= lat_we_n;
      lat_ctl    <= lat_ctl_n;
      last_grant <= last_n;
      cnt        <= cnt_n;
      sel_ram    <= sel_ram_n;
      sel_ctl    <= sel_ctl_n;
      we         <= we_n;
      r0_ack     <= ack0_n;
      r1_ack     <= ack1_n;
      busy       <= busy_n;
      addr       <= addr_n;
      din        <= din_n;
      rdata      <= rdata_n;
    end
  end

endmodule

// File: tb/tb_video_bus_arb.sv
// Scoreboard bench for video_bus_arb (RD_LAT=2, BLANK_ONLY=1).
// Stimulus queues expected strobes/acks; a monitor pops and compares.
module tb_video_bus_arb;

  localparam int AW = 13;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          NRST;
  logic          vid_blank;
  logic          r0_req, r0_we, r0_ctl, r0_ack;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata;
  logic          r1_req, r1_we, r1_ctl, r1_ack;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata;
  logic [DW-1:0] rdata, din, ram_dout, ctl_dout;
  logic [AW-1:0] addr;
  logic          sel_ram, sel_ctl, we, busy;

  video_bus_arb #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .BLANK_ONLY(1)
  ) dut (
    .clk(clk), .NRST(NRST), .vid_blank(vid_blank),
    .r0_req(r0_req), .r0_we(r0_we), .r0_ctl(r0_ctl),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_ack(r0_ack),
    .r1_req(r1_req), .r1_we(r1_we), .r1_ctl(r1_ctl),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_ack(r1_ack),
    .rdata(rdata), .sel_ram(sel_ram), .sel_ctl(sel_ctl),
    .we(we), .addr(addr), .din(din),
    .ram_dout(ram_dout), .ctl_dout(ctl_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            c;
    logic          sr;
    logic          sc;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } stb_t;

  typedef struct {
    int            c;
    logic          id;
    logic          rd;
    logic [DW-1:0] rdat;
  } ack_t;

  stb_t sq[$];
  ack_t aq[$];
  stb_t se;
  ack_t ae;
  int   errors = 0;
  int   checks = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  task automatic exp_stb(int c, logic sr, logic sc, logic w,
                         logic [AW-1:0] a, logic [DW-1:0] d);
    sq.push_back('{c: c, sr: sr, sc: sc, w: w, a: a, d: d});
  endtask

  task automatic exp_ack(int c, logic id, logic rd,
                         logic [DW-1:0] rv);
    aq.push_back('{c: c, id: id, rd: rd, rdat: rv});
  endtask

  task automatic goto(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_ack(logic id, int budget);
    int n = 0;
    while (!(id ? r1_ack : r0_ack) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL ack_timeout: r%0d ack not seen in %0d cycles",
               id, budget);
    end
  endtask

  // Monitor: compare every presented strobe and ack with the queues.
  always @(negedge clk) begin
    if (NRST) begin
      if (sel_ram | sel_ctl | we)
        chk("excl", {30'd0, sel_ram & sel_ctl,
                     we & ~(sel_ram | sel_ctl)}, 32'd0);
      if (sel_ram | sel_ctl) begin
        if (sq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got sel=%b%b at cycle %0d expected none",
                   sel_ram, sel_ctl, cyc);
        end else begin
          se = sq.pop_front();
          chk("stb_cyc", cyc, se.c);
          chk("stb_sel", {29'd0, sel_ram, sel_ctl, we},
              {29'd0, se.sr, se.sc, se.w});
          chk("stb_addr", 32'(addr), 32'(se.a));
          chk("stb_din", 32'(din), 32'(se.d));
        end
      end
      if (r0_ack | r1_ack) begin
        if (aq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got r0=%b r1=%b at cycle %0d expected none",
                   r0_ack, r1_ack, cyc);
        end else begin
          ae = aq.pop_front();
          chk("ack_cyc", cyc, ae.c);
          chk("ack_id", {30'd0, r1_ack, r0_ack},
              ae.id ? 32'd2 : 32'd1);
          if (ae.rd) chk("ack_rdata", 32'(rdata), 32'(ae.rdat));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    NRST = 1'b0; vid_blank = 1'b1;
    r0_req = 0; r0_we = 0; r0_ctl = 0; r0_addr = '0; r0_wdata = '0;
    r1_req = 0; r1_we = 0; r1_ctl = 0; r1_addr = '0; r1_wdata = '0;
    ram_dout = 8'h99; ctl_dout = 8'h3C;
    repeat (2) @(negedge clk);
    chk("rst_ctl", {26'd0, sel_ram, sel_ctl, we, r0_ack, r1_ack, busy},
        32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_din", 32'(din), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    NRST = 1'b1;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // r0 VRAM write
    k = cyc;
    r0_req = 1; r0_we = 1; r0_ctl = 0;
    r0_addr = 13'h0123; r0_wdata = 8'hA5;
    exp_stb(k + 1, 1, 0, 1, 13'h0123, 8'hA5);
    exp_ack(k + 2, 0, 0, 8'h00);
    @(negedge clk);
    chk("wr_busy", {31'd0, busy}, 32'd1);
    wait_ack(0, 10);
    r0_req = 0;
    @(negedge clk);
    chk("wr_addr_hold", 32'(addr), 32'h0123);
    chk("wr_busy_done", {31'd0, busy}, 32'd0);

    // r1 control read, RD_LAT=2
    k = cyc;
    r1_req = 1; r1_we = 0; r1_ctl = 1;
    r1_addr = 13'h0004; r1_wdata = 8'h00;
    exp_stb(k + 1, 0, 1, 0, 13'h0004, 8'h00);
    exp_ack(k + 4, 1, 1, 8'h3C);
    wait_ack(1, 12);
    r1_req = 0;
    @(negedge clk);
    chk("rd_hold", 32'(rdata), 32'h3C);

    // both request continuously: strict alternation 0,1,0,1
    k = cyc;
    r0_req = 1; r0_we = 1; r0_ctl = 0;
    r0_addr = 13'h0010; r0_wdata = 8'h11;
    r1_req = 1; r1_we = 1; r1_ctl = 1;
    r1_addr = 13'h0020; r1_wdata = 8'h22;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) exp_stb(k + 3 * i + 1, 1, 0, 1, 13'h0010, 8'h11);
      else            exp_stb(k + 3 * i + 1, 0, 1, 1, 13'h0020, 8'h22);
      exp_ack(k + 3 * i + 2, (i % 2) == 1, 0, 8'h00);
    end
    goto(k + 11);
    r0_req = 0; r1_req = 0;
    @(negedge clk);
    chk("rd_not_on_wr", 32'(rdata), 32'h3C);

    // blanking gate: r0 VRAM waits, r1 control served
    vid_blank = 0;
    k = cyc;
    r0_req = 1; r0_we = 1; r0_ctl = 0;
    r0_addr = 13'h00AA; r0_wdata = 8'h55;
    r1_req = 1; r1_we = 1; r1_ctl = 1;
    r1_addr = 13'h0005; r1_wdata = 8'h66;
    exp_stb(k + 1, 0, 1, 1, 13'h0005, 8'h66);
    exp_ack(k + 2, 1, 0, 8'h00);
    wait_ack(1, 10);
    r1_req = 0;
    goto(k + 4);
    chk("gated_busy", {31'd0, busy}, 32'd0);
    goto(k + 5);
    vid_blank = 1;
    exp_stb(k + 6, 1, 0, 1, 13'h00AA, 8'h55);
    exp_ack(k + 7, 0, 0, 8'h00);
    wait_ack(0, 10);
    r0_req = 0;
    @(negedge clk);

    // reset during WAIT of a read
    k = cyc;
    ram_dout = 8'h42;
    r0_req = 1; r0_we = 0; r0_ctl = 0;
    r0_addr = 13'h0777; r0_wdata = 8'h00;
    exp_stb(k + 1, 1, 0, 0, 13'h0777, 8'h00);
    goto(k + 2);
    NRST = 0;
    #1;
    chk("arst_ctl", {26'd0, sel_ram, sel_ctl, we, r0_ack, r1_ack, busy},
        32'd0);
    chk("arst_addr", 32'(addr), 32'd0);
    r0_req = 0;
    repeat (2) @(negedge clk);
    NRST = 1;
    repeat (6) @(negedge clk);
    chk("arst_rdata", 32'(rdata), 32'd0);

    // tie after reset goes to r0
    k = cyc;
    r0_req = 1; r0_we = 1; r0_ctl = 1;
    r0_addr = 13'h0001; r0_wdata = 8'h77;
    r1_req = 1; r1_we = 1; r1_ctl = 0;
    r1_addr = 13'h0002; r1_wdata = 8'h88;
    exp_stb(k + 1, 0, 1, 1, 13'h0001, 8'h77);
    exp_ack(k + 2, 0, 0, 8'h00);
    exp_stb(k + 4, 1, 0, 1, 13'h0002, 8'h88);
    exp_ack(k + 5, 1, 0, 8'h00);
    wait_ack(0, 10);
    r0_req = 0;
    wait_ack(1, 10);
    r1_req = 0;
    @(negedge clk);

    // command change during ISSUE takes effect on the next grant
    k = cyc;
    r0_req = 1; r0_we = 1; r0_ctl = 0;
    r0_addr = 13'h0100; r0_wdata = 8'h01;
    exp_stb(k + 1, 1, 0, 1, 13'h0100, 8'h01);
    exp_ack(k + 2, 0, 0, 8'h00);
    exp_stb(k + 4, 1, 0, 1, 13'h0200, 8'h02);
    exp_ack(k + 5, 0, 0, 8'h00);
    @(negedge clk);
    r0_addr = 13'h0200; r0_wdata = 8'h02;
    goto(k + 5);
    r0_req = 0;

    repeat (4) @(negedge clk);
    chk("stb_queue_empty", sq.size(), 32'd0);
    chk("ack_queue_empty", aq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_bus_arb.md
Name: video_bus_arb

Overview:
- Two-requester arbiter and sequencer for the video block's host port (sel_ram, sel_ctl, we, addr, din, ram_dout, ctl_dout), which is currently tied off at top level.
- Lets a boot/init loader (requester 0) and a host interface (requester 1) share VRAM and control-register access.
- Uses round-robin grant, registered strobes, fixed read latency, and optional restriction of VRAM accesses to blanking.

Parameters:
- ADDR_W, 13, video address width.
- DATA_W, 8, data width.
- RD_LAT, 1, cycles from read strobe to valid ram_dout/ctl_dout; legal range 1..7.
- BLANK_ONLY, 0, if 1 VRAM accesses are granted only while vid_blank=1; control accesses are never gated.

Ports:
- clk  in  1  system clock; single clock domain.
- NRST  in  1  asynchronous active-low reset.
- vid_blank  in  1  high during video blanking, synchronous to clk.
- rN_req  in  1  (N=0,1) access request; hold high until rN_ack.
- rN_we  in  1  1=write, 0=read.
- rN_ctl  in  1  1=control space, 0=VRAM.
- rN_addr  in  ADDR_W  access address.
- rN_wdata  in  DATA_W  write data.
- rN_ack  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  read data; valid in the ack cycle of a read.
- sel_ram  out  1  VRAM strobe to video.
- sel_ctl  out  1  control strobe to video.
- we  out  1  write enable to video.
- addr  out  ADDR_W  address to video.
- din  out  DATA_W  write data to video.
- ram_dout  in  DATA_W  VRAM read data from video.
- ctl_dout  in  DATA_W  control read data from video.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- All outputs are registered. At reset, and asynchronously while NRST=0: sel_ram, sel_ctl, we, r0_ack, r1_ack and busy are 0; addr, din and rdata are 0; FSM is IDLE; last_grant=1, so requester 0 wins the first tie.
- Eligibility: rN_req=1 AND (rN_ctl=1 OR BLANK_ONLY=0 OR vid_blank=1).
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Evaluates eligibility each cycle.
  - If only one requester is eligible, grant it.
  - If both are eligible, grant the one that is not last_grant.
  - If neither is eligible, stay in IDLE.
  - On grant: latch we, ctl, addr and wdata from the granted requester, set last_grant, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - sel_ram=~ctl, sel_ctl=ctl, we=latched we, addr/din driven from the latch.
  - Write -> go to ACK. Read -> go to WAIT with counter=RD_LAT.
- WAIT:
  - sel_ram, sel_ctl and we are 0; counter decrements each cycle.
  - On the cycle the counter reaches 1, capture rdata from ram_dout (VRAM) or ctl_dout (control), then go to ACK.
- ACK:
  - rN_ack=1 for the granted requester only, for exactly 1 cycle; then return to IDLE.
  - rdata holds its value until the next read capture. It is not updated on writes.
- Latency, counting the cycle in which req is sampled in IDLE as cycle 0:
  - Write: strobe in cycle 1, ack in cycle 2.
  - Read: strobe in cycle 1, ack in cycle 2+RD_LAT.
- Throughput: one access per 3 cycles (write) or 3+RD_LAT cycles (read). A requester holding req high after ack is re-evaluated in the following IDLE cycle.
- addr and din hold their last values outside ISSUE. Only sel_* and we return to 0.
- Requester inputs are ignored between grant and ack. Command changes take effect only on the next grant.
- If vid_blank falls after grant, the granted access still completes. Gating applies only at grant time.
- Starvation: under continuous eligible requests from both sides, grants alternate strictly.
- An ineligible VRAM request does not block an eligible request from the other requester.
- Reset asserted mid-access: the access is abandoned, no ack is issued, and strobes drop immediately (asynchronous). After reset, operation resumes from IDLE with last_grant=1.
- sel_ram and sel_ctl are never both 1. we=1 only when one of them is 1.

Test Plan:
- Reset, then r0 write ctl=0 addr=0x0123 wdata=0xA5 -> cycle 1: sel_ram=1, we=1, addr=0x0123, din=0xA5; cycle 2: r0_ack=1; all strobes 0 otherwise.
- RD_LAT=2; r1 read ctl=1 addr=0x0004 with ctl_dout=0x3C -> sel_ctl=1, we=0 in cycle 1; r1_ack=1 and rdata=0x3C in cycle 4.
- r0 and r1 both request continuously (writes) -> grant order 0,1,0,1; acks alternate every 3 cycles; no overlapping strobes.
- BLANK_ONLY=1, vid_blank=0: r0 VRAM write plus r1 ctl write -> r1 served, r0 waits; raise vid_blank -> r0 strobed on the next IDLE evaluation.
- Assert NRST during WAIT of a read -> strobes, ack and busy are 0 immediately; no ack after release; the next tie grants r0.
- Hold r0_req after ack and change r0_addr during ISSUE -> in-flight access uses the latched address; the new address appears on the next grant.
